// File: rtl/decode_stage_pkg.sv
// Shared processor constants: opcode, ALU operation and decode FSM encodings,
// plus the decoded-control bundle passed from ID to EX.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MOV   = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_STACK = 4'd7,
    OP_LDM   = 4'd12
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_PASS_B   = 3'd0,
    ALU_ADD      = 3'd1,
    ALU_SUB      = 3'd2,
    ALU_AND      = 3'd3,
    ALU_OR       = 3'd4,
    ALU_DEC_A    = 3'd5,
    ALU_PASS_IMM = 3'd6
  } alu_op_t;

  typedef enum logic [0:0] {
    S_OP  = 1'b0,
    S_IMM = 1'b1
  } state_t;

  // Stack pointer lives in r3.
  localparam logic [1:0] SP_REG = 2'd3;

  typedef struct packed {
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] adder;
    logic       wr_en;
    logic       sp_inc;
    logic       mem_wr;
    alu_op_t    alu_op;
    logic [7:0] imm;
    logic       valid;
  } ctrl_t;

  // A bubble drives every field to zero, including the don't-care ones.
  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode byte handshake.
interface decode_stage_if;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/decode_logic.sv
// Combinational byte-to-control decode. In S_IMM the byte is an immediate
// for the pending LDM; otherwise it is an opcode byte.
module decode_logic
  import decode_stage_pkg::*;
(
  input  logic [7:0] instr,
  input  state_t     state,
  input  logic [1:0] ra_lat,
  output ctrl_t      ctrl,
  output logic       ldm_start
);

  logic [1:0] ra, rb;
  assign ra = instr[3:2];
  assign rb = instr[1:0];

  // Decode one byte into an ID/EX control bundle.
  always_comb begin
    ctrl      = CTRL_BUBBLE;
    ldm_start = 1'b0;
    if (state == S_IMM) begin
      ctrl.adder  = ra_lat;
      ctrl.wr_en  = 1'b1;
      ctrl.alu_op = ALU_PASS_IMM;
      ctrl.imm    = instr;
      ctrl.valid  = 1'b1;
    end else begin
      case (opcode_t'(instr[7:4]))
        OP_MOV, OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          ctrl.ra    = ra;
          ctrl.rb    = rb;
          ctrl.adder = ra;
          ctrl.wr_en = 1'b1;
          ctrl.valid = 1'b1;
          case (opcode_t'(instr[7:4]))
            OP_ADD:  ctrl.alu_op = ALU_ADD;
            OP_SUB:  ctrl.alu_op = ALU_SUB;
            OP_AND:  ctrl.alu_op = ALU_AND;
            OP_OR:   ctrl.alu_op = ALU_OR;
            default: ctrl.alu_op = ALU_PASS_B;
          endcase
        end
        OP_STACK: begin
          ctrl.ra    = SP_REG;
          ctrl.wr_en = 1'b1;
          ctrl.valid = 1'b1;
          if (rb[0]) begin
            // POP: rd <- mem[sp], sp++
            ctrl.adder  = ra;
            ctrl.sp_inc = 1'b1;
            ctrl.alu_op = ALU_PASS_B;
          end else begin
            // PUSH: mem[sp-1] <- rs, sp--
            ctrl.rb     = ra;
            ctrl.adder  = SP_REG;
            ctrl.mem_wr = 1'b1;
            ctrl.alu_op = ALU_DEC_A;
          end
        end
        OP_LDM: begin
          // First half of LDM produces a bubble; the immediate follows.
          ldm_start = 1'b1;
        end
        default: begin
          // NOP and undefined opcodes: a real but effect-free instruction.
          ctrl.valid = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: LDM two-byte FSM plus ID/EX output registers.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  fi,
  input  logic           stall,
  input  logic           flush,
  output logic [1:0]     RA,
  output logic [1:0]     RB,
  output logic [1:0]     ADDER,
  output logic           wr_en,
  output logic           SP_INC,
  output logic           mem_wr,
  output logic [2:0]     alu_op,
  output logic [7:0]     imm,
  output logic           valid_out
);

  state_t     state;
  logic [1:0] ra_lat;
  ctrl_t      ctrl_d, ctrl_q;
  logic       ldm_start;

  decode_logic u_dec (
    .instr     (fi.instr),
    .state     (state),
    .ra_lat    (ra_lat),
    .ctrl      (ctrl_d),
    .ldm_start (ldm_start)
  );

  assign fi.instr_ready = ~stall;

  // FSM and ID/EX registers; flush beats stall, stall beats a new byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_OP;
      ra_lat <= 2'd0;
      ctrl_q <= CTRL_BUBBLE;
    end else if (flush) begin
      state  <= S_OP;
      ra_lat <= 2'd0;
      ctrl_q <= CTRL_BUBBLE;
    end else if (!stall) begin
      if (fi.instr_valid) begin
        ctrl_q <= ctrl_d;
        if (state == S_IMM) begin
          state <= S_OP;
        end else if (ldm_start) begin
          state  <= S_IMM;
          ra_lat <= fi.instr[3:2];
        end
      end else begin
        ctrl_q <= CTRL_BUBBLE;
      end
    end
  end

  assign RA        = ctrl_q.ra;
  assign RB        = ctrl_q.rb;
  assign ADDER     = ctrl_q.adder;
  assign wr_en     = ctrl_q.wr_en;
  assign SP_INC    = ctrl_q.sp_inc;
  assign mem_wr    = ctrl_q.mem_wr;
  assign alu_op    = ctrl_q.alu_op;
  assign imm       = ctrl_q.imm;
  assign valid_out = ctrl_q.valid;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: ALU ops, stack ops, LDM, stall, flush, reset.
module tb_decode_stage;
  import decode_stage_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall, flush;
  logic [1:0] RA, RB, ADDER;
  logic       wr_en, SP_INC, mem_wr, valid_out;
  logic [2:0] alu_op;
  logic [7:0] imm;
  int         checks = 0;
  int         errors = 0;

  decode_stage_if fi ();

  decode_stage dut (
    .clk       (clk),
    .rst       (rst),
    .fi        (fi.slave),
    .stall     (stall),
    .flush     (flush),
    .RA        (RA),
    .RB        (RB),
    .ADDER     (ADDER),
    .wr_en     (wr_en),
    .SP_INC    (SP_INC),
    .mem_wr    (mem_wr),
    .alu_op    (alu_op),
    .imm       (imm),
    .valid_out (valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every registered output against hand-computed values.
  task automatic chk_out(input string tag,
                         input logic [1:0] e_ra, input logic [1:0] e_rb, input logic [1:0] e_ad,
                         input logic e_wr, input logic e_sp, input logic e_mw,
                         input logic [2:0] e_alu, input logic [7:0] e_imm, input logic e_vld);
    chk({tag, ".RA"},     32'(RA),        32'(e_ra));
    chk({tag, ".RB"},     32'(RB),        32'(e_rb));
    chk({tag, ".ADDER"},  32'(ADDER),     32'(e_ad));
    chk({tag, ".wr_en"},  32'(wr_en),     32'(e_wr));
    chk({tag, ".SP_INC"}, 32'(SP_INC),    32'(e_sp));
    chk({tag, ".mem_wr"}, 32'(mem_wr),    32'(e_mw));
    chk({tag, ".alu_op"}, 32'(alu_op),    32'(e_alu));
    chk({tag, ".imm"},    32'(imm),       32'(e_imm));
    chk({tag, ".valid"},  32'(valid_out), 32'(e_vld));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] b, input logic v);
    fi.instr       = b;
    fi.instr_valid = v;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(8'h00, 1'b0);
    tick(); tick();
    chk_out("reset", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("reset.state", 32'(dut.state), 32'(S_OP));
    rst = 1'b1;
    tick();

    // ADD r1,r2
    drive(8'h26, 1'b1);
    #1 chk("add.ready", 32'(fi.instr_ready), 32'd1);
    tick();
    chk_out("add", 2'd1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1);

    // LDM r2, 0x5A
    drive(8'hC8, 1'b1); tick();
    chk_out("ldm1", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("ldm1.state", 32'(dut.state), 32'(S_IMM));
    drive(8'h5A, 1'b1); tick();
    chk_out("ldm2", 2'd0, 2'd0, 2'd2, 1'b1, 1'b0, 1'b0, 3'd6, 8'h5A, 1'b1);
    chk("ldm2.state", 32'(dut.state), 32'(S_OP));

    // POP r0, PUSH r1
    drive(8'h71, 1'b1); tick();
    chk_out("pop", 2'd3, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1);
    drive(8'h74, 1'b1); tick();
    chk_out("push", 2'd3, 2'd1, 2'd3, 1'b1, 1'b0, 1'b1, 3'd5, 8'h00, 1'b1);

    // Idle cycle is a bubble
    drive(8'h26, 1'b0); tick();
    chk_out("idle", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);

    // LDM pending with no byte: stays in S_IMM, bubble
    drive(8'hC4, 1'b1); tick();
    drive(8'h00, 1'b0); tick();
    chk("ldmwait.state", 32'(dut.state), 32'(S_IMM));
    chk("ldmwait.valid", 32'(valid_out), 32'd0);
    drive(8'h11, 1'b1); tick();
    chk_out("ldmwait.imm", 2'd0, 2'd0, 2'd1, 1'b1, 1'b0, 1'b0, 3'd6, 8'h11, 1'b1);

    // Stall: SUB r2,r1 then hold 0x26 under stall for 3 cycles
    drive(8'h39, 1'b1); tick();
    chk_out("sub", 2'd2, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1);
    drive(8'h26, 1'b1); stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("stall.ready", 32'(fi.instr_ready), 32'd0);
      tick();
      chk_out("stall", 2'd2, 2'd1, 2'd2, 1'b1, 1'b0, 1'b0, 3'd2, 8'h00, 1'b1);
      chk("stall.state", 32'(dut.state), 32'(S_OP));
    end
    stall = 1'b0; tick();
    chk_out("unstall", 2'd1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1);
    drive(8'h26, 1'b0); tick();
    chk("unstall.once", 32'(valid_out), 32'd0);

    // Stall mid-LDM keeps S_IMM and latched ra
    drive(8'hCC, 1'b1); tick();
    stall = 1'b1; drive(8'h77, 1'b1); tick();
    chk("stallimm.state", 32'(dut.state), 32'(S_IMM));
    stall = 1'b0; tick();
    chk_out("stallimm", 2'd0, 2'd0, 2'd3, 1'b1, 1'b0, 1'b0, 3'd6, 8'h77, 1'b1);

    // Flush drops half-received LDM, even with stall asserted
    drive(8'hC8, 1'b1); tick();
    flush = 1'b1; stall = 1'b1; drive(8'h5A, 1'b1); tick();
    chk_out("flush", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("flush.state", 32'(dut.state), 32'(S_OP));
    flush = 1'b0; stall = 1'b0; drive(8'h26, 1'b1); tick();
    chk_out("postflush", 2'd1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0, 3'd1, 8'h00, 1'b1);

    // Async reset clears outputs without a clock edge
    #2 rst = 1'b0;
    #1 chk_out("asyncrst", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b1;
    drive(8'h00, 1'b0); tick();

    // Reset between LDM bytes: 0x5A decodes as OR r2,r2
    drive(8'hC8, 1'b1); tick();
    chk("rstldm.pre", 32'(dut.state), 32'(S_IMM));
    #2 rst = 1'b0;
    #1 chk("rstldm.state", 32'(dut.state), 32'(S_OP));
    chk_out("rstldm", 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0);
    rst = 1'b1;
    drive(8'h5A, 1'b1); tick();
    chk_out("or", 2'd2, 2'd2, 2'd2, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single processor clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port instr, input, 8 bits: fetched byte; [7:4] opcode, [3:2] ra, [1:0] rb.
REQ-004 SHALL have port instr_valid, input, 1 bit: instr holds a valid byte this cycle.
REQ-005 SHALL have port stall, input, 1 bit: hold all state and outputs.
REQ-006 SHALL have port flush, input, 1 bit: discard in-flight decode.
REQ-007 SHALL have port instr_ready, output, 1 bit: byte accepted this cycle; equals ~stall.
REQ-008 SHALL have ports RA and RB, output, 2 bits each: register-file read addresses.
REQ-009 SHALL have port ADDER, output, 2 bits: register-file write address.
REQ-010 SHALL have ports wr_en and SP_INC, output, 1 bit each: register-file write enable and stack-pointer increment.
REQ-011 SHALL have port mem_wr, output, 1 bit: data-memory write (PUSH).
REQ-012 SHALL have port alu_op, output, 3 bits: EX operation.
REQ-013 SHALL have port imm, output, 8 bits: immediate operand.
REQ-014 SHALL have port valid_out, output, 1 bit: outputs describe a real instruction.

Function
REQ-015 SHALL register all outputs except instr_ready, giving one-cycle latency from an accepted byte to its decoded outputs.
REQ-016 SHALL accept a byte only when instr_valid=1 and stall=0.
REQ-017 SHALL use opcodes 0 NOP, 1 MOV, 2 ADD, 3 SUB, 4 AND, 5 OR, 7 STACK, 12 LDM; all other opcodes decode as NOP.
REQ-018 SHALL decode MOV/ADD/SUB/AND/OR as RA=ra, RB=rb, ADDER=ra, wr_en=1, alu_op PASS_B/ADD/SUB/AND/OR (0/1/2/3/4).
REQ-019 SHALL decode STACK with rb[0]=0 (PUSH) as RA=3, RB=ra, ADDER=3, wr_en=1, mem_wr=1, alu_op DEC_A (5).
REQ-020 SHALL decode STACK with rb[0]=1 (POP) as RA=3, ADDER=ra, wr_en=1, SP_INC=1, alu_op PASS_B (0).
REQ-021 SHALL handle LDM as two bytes using FSM states S_OP and S_IMM.
REQ-022 In S_OP, an accepted LDM byte SHALL latch ra, move to S_IMM, and emit a bubble.
REQ-023 In S_IMM, the next accepted byte SHALL be taken as imm and emit ADDER=ra, wr_en=1, alu_op PASS_IMM (6), valid_out=1, then return to S_OP.
REQ-024 In S_IMM with no accepted byte, the FSM SHALL stay in S_IMM and emit a bubble.
REQ-025 A bubble SHALL mean valid_out=0, wr_en=0, SP_INC=0, mem_wr=0; RA, RB, ADDER, alu_op and imm are don't-care but SHALL be driven 0.
REQ-026 With instr_valid=0 and stall=0, the block SHALL emit a bubble.
REQ-027 With stall=1, the block SHALL hold outputs, FSM state and latched ra unchanged.
REQ-028 With flush=1, the block SHALL emit a bubble next cycle, go to S_OP and drop any half-received LDM; flush overrides stall and instr_valid.
REQ-029 An opcode byte arriving with flush=1 SHALL be discarded.

Reset
REQ-030 While rst=0, the block SHALL force the FSM to S_OP, all registered outputs to 0, and latched ra to 0, independent of clk.
REQ-031 Reset asserted mid-LDM SHALL abandon it; the first accepted byte after release SHALL be decoded as an opcode.

Structure
REQ-032 Opcode, alu_op and FSM state encodings SHALL live in the shared processor constants package used by EX.
REQ-033 Byte-to-control decode SHALL be one combinational sub-module, decode_logic; decode_stage SHALL hold the FSM and ID/EX registers.

Verification
REQ-034 The bench SHALL check: reset, then ADD r1,r2 (0x26) valid -> next cycle RA=1, RB=2, ADDER=1, wr_en=1, alu_op=1, valid_out=1.
REQ-035 The bench SHALL check: LDM r2 (0xC8) then 0x5A on consecutive cycles -> bubble, then ADDER=2, imm=0x5A, alu_op=6, wr_en=1.
REQ-036 The bench SHALL check: POP r0 (0x71) -> RA=3, ADDER=0, SP_INC=1, wr_en=1; PUSH r1 (0x74) -> RA=3, RB=1, ADDER=3, mem_wr=1, alu_op=5.
REQ-037 The bench SHALL check: 0x26 with stall=1 held 3 cycles -> outputs and state frozen, instr_ready=0; after release, 0x26 decodes once.
REQ-038 The bench SHALL check: 0xC8, then flush=1 with 0x5A -> bubble, FSM S_OP; following 0x26 decodes as ADD.
REQ-039 The bench SHALL check: rst pulsed low between 0xC8 and 0x5A -> outputs 0 immediately; 0x5A then decodes as opcode 5 (OR r2,r2).
